// File: rtl/count_pwm_gen.sv
// -----------------------------------------------------------------------------
// count_pwm_gen
//
// Purpose:
//   Consumes the value of a free-running counter and generates a glitch-free
//   PWM output. The duty value is double-buffered: a new value is accepted into
//   a shadow register through a valid/ready handshake. It becomes the active
//   duty only at a period boundary. A run/drain state machine makes the output
//   start and stop only on whole periods.
//
// Optional feature (compile-time macro DEADTIME_EN):
//   When defined, pwm_out and the complementary output pwm_n_out each rise only
//   after the compare result has been stable for DEAD cycles, which creates a
//   dead band between the two outputs. When undefined, pwm_n_out is tied low
//   and DEAD has no effect.
//
// Ports:
//   clk          in   Clock, rising edge.
//   rst_n        in   Asynchronous active-low reset.
//   ena          in   Clock enable; 0 holds all state and outputs.
//   count_in     in   Counter value from the upstream counter (WIDTH bits).
//   enable_in    in   Run request, level-sensitive.
//   duty_in      in   New duty value (WIDTH bits).
//   duty_valid   in   duty_in is valid.
//   duty_ready   out  Shadow register can accept a value (combinational).
//   pwm_out      out  Registered PWM output.
//   pwm_n_out    out  Complementary dead-band output (DEADTIME_EN only, else 0).
//   period_tick  out  One-cycle pulse after each boundary while RUN or DRAIN.
//   busy         out  State machine is not IDLE (registered).
//   state_dbg    out  Current FSM state, for observation only.
// -----------------------------------------------------------------------------
module count_pwm_gen #(
    parameter int WIDTH = 8,
    parameter int DEAD  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] count_in,
    input  logic             enable_in,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_out,
    output logic             pwm_n_out,
    output logic             period_tick,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        RUN       = 2'd2,
        DRAIN     = 2'd3
    } state_t;

    state_t           state;
    state_t           nxt;
    logic [WIDTH-1:0] active_duty;
    logic [WIDTH-1:0] shadow;
    logic             pending;
    logic             pwm_q;
    logic             tick_q;
    logic             busy_q;

    logic             boundary;
    logic             accept;
    logic             run_next;
    logic [WIDTH-1:0] eff_duty;
    logic             raw;

    // A negative dead band has no meaning; this empty block only exists when
    // the parameter is out of range, which makes the misuse easy to spot.
    if (DEAD < 0) begin : g_dead_out_of_range
    end

    // A boundary is any enabled cycle that sees count zero. Wrap-around is not
    // inferred from the previous count.
    assign boundary = ena && (count_in == '0);

    // Duty handshake: a transfer happens in any cycle where duty_valid and
    // duty_ready are both 1. duty_ready depends only on ena and pending, never
    // on duty_valid. The producer must hold duty_in while duty_valid is high
    // and duty_ready is low. While a value is pending, duty_valid is ignored
    // and nothing is captured.
    assign duty_ready = ena && !pending;
    assign accept     = duty_valid && duty_ready;

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:      if (enable_in) nxt = WAIT_SYNC;
            WAIT_SYNC: begin
                if (!enable_in)    nxt = IDLE;
                else if (boundary) nxt = RUN;
            end
            RUN:       if (!enable_in) nxt = DRAIN;
            DRAIN:     if (boundary) nxt = enable_in ? RUN : IDLE;
            default:   nxt = IDLE;
        endcase
    end

    // The compare uses the post-transition state. The first period then
    // includes its boundary cycle, and a drain that ends at a boundary does not
    // leak a pulse into the next period.
    assign run_next = (nxt == RUN) || (nxt == DRAIN);

    // A duty value applied at this boundary already governs this boundary's
    // compare, so a new period uses one duty value from count zero onward.
    assign eff_duty = (boundary && pending) ? shadow : active_duty;
    assign raw      = run_next && (count_in < eff_duty);

`ifdef DEADTIME_EN
    localparam int             CW     = $clog2(DEAD + 2);
    localparam logic [CW-1:0]  DEAD_C = CW'(DEAD);

    // Length of the current run of raw high or raw low, saturating at DEAD.
    logic [CW-1:0] hi_len;
    logic [CW-1:0] lo_len;
    logic          pwm_n_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            active_duty <= '0;
            shadow      <= '0;
            pending     <= 1'b0;
            pwm_q       <= 1'b0;
            tick_q      <= 1'b0;
            busy_q      <= 1'b0;
`ifdef DEADTIME_EN
            hi_len      <= '0;
            lo_len      <= '0;
            pwm_n_q     <= 1'b0;
`endif
        end else if (ena) begin
            state <= nxt;

            if (boundary && pending) begin
                active_duty <= shadow;
                pending     <= 1'b0;
            end
            // accept requires pending==0, so it never collides with the
            // boundary update above. An accept in a boundary cycle waits for
            // the next boundary.
            if (accept) begin
                shadow  <= duty_in;
                pending <= 1'b1;
            end

            tick_q <= boundary && run_next;
            busy_q <= (nxt != IDLE);

`ifdef DEADTIME_EN
            // Each output rises only once raw has held its level for DEAD
            // cycles. It falls with raw, so the two outputs are never high
            // together and short levels are dropped.
            pwm_q   <= raw && (hi_len >= DEAD_C);
            pwm_n_q <= !raw && run_next && (lo_len >= DEAD_C);
            if (raw) begin
                lo_len <= '0;
                if (hi_len < DEAD_C) hi_len <= hi_len + CW'(1);
            end else begin
                hi_len <= '0;
                if (lo_len < DEAD_C) lo_len <= lo_len + CW'(1);
            end
`else
            pwm_q <= raw;
`endif
        end
    end

    assign pwm_out     = pwm_q;
    assign period_tick = tick_q;
    assign busy        = busy_q;
    assign state_dbg   = state;

`ifdef DEADTIME_EN
    assign pwm_n_out = pwm_n_q;
`else
    assign pwm_n_out = 1'b0;
`endif

endmodule
